reg_wb_unit: RTL and testbench
==============================

# reg_wb_unit

Writeback stage that owns the register file write port and merges results from two producers: the single-cycle ALU/load pipeline and the multi-cycle multiply/divide unit (MDU). ALU results have priority. MDU results are buffered in a small FIFO, and a starvation counter forces a drain slot when the FIFO head waits too long. The block also publishes a pending-destination mask so decode can stall reads that would otherwise see stale data.

## Interface
Parameters:
- FIFO_DEPTH, 2: MDU result buffer depth; power of two, ≥2.
- STARVE_LIMIT, 4: cycles a FIFO head may wait before a forced drain slot; ≥1.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU/load result present this cycle; no backpressure.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_stall  out  1  registered; upstream must hold alu_valid=0 this cycle.
- mdu_valid  in  1  MDU result offered.
- mdu_ready  out  1  FIFO can accept; depends on state only, not on mdu_valid.
- mdu_rd  in  5  MDU destination register.
- mdu_data  in  32  MDU result.
- write_en  out  1  registered write strobe to register file.
- write_addr  out  5  registered write address.
- write_data  out  32  registered write data.
- busy_mask  out  32  bit r set while a write to xr is pending.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- err_waw  out  1  sticky protocol-violation flag.

## Operation
- Slot selection each cycle, by priority: (1) ALU if alu_valid && alu_rd!=0 && !alu_stall; (2) FIFO head if non-empty; (3) accepted MDU result if FIFO empty (bypass, no enqueue); (4) idle.
- MDU handshake: transfer when mdu_valid && mdu_ready. An accepted result not taken by the bypass is enqueued. If the FIFO pops this cycle, push and pop happen together.
- mdu_ready = (fifo_count < FIFO_DEPTH).
- x0 filtering: results with rd==0 are never written. An MDU rd==0 transfer completes the handshake and is discarded without enqueue. An ALU rd==0 result is ignored.
- busy_mask: OR of one-hot(rd) over all FIFO entries, plus one-hot(write_addr) when write_en=1. Bit 0 is always 0.
- Starvation counter: cleared on pop or when the FIFO is empty; otherwise increments while the head waits. When it reaches STARVE_LIMIT, alu_stall=1 for exactly the next cycle, and the head pops in that cycle.
- err_waw is set and held until reset in either case:
  - alu_valid arrives with busy_mask[alu_rd]=1 (for alu_rd!=0).
  - alu_valid=1 while alu_stall=1. That ALU result is dropped.
- Reset mid-operation drops all FIFO contents and any in-flight write. No write is issued in the cycle after reset.

## Timing
- Reset values: write_en=0, write_addr=0, write_data=0, alu_stall=0, busy_mask=0, fifo_count=0, err_waw=0, mdu_ready=1 (once rst is low).
- ALU latency: result at edge N gives write_en=1 during cycle N+1.
- MDU bypass latency: accepted at N into an empty FIFO with no ALU result gives a write in cycle N+1.
- Queued MDU latency: write occurs no later than STARVE_LIMIT+2 cycles after reaching the head, under continuous ALU traffic.
- Full FIFO with simultaneous pop: mdu_ready is still 0 that cycle. There is no combinational ready path.
- FIFO read and write pointers wrap modulo FIFO_DEPTH. Order is strict FIFO.

## Structure
- Shared `core_pkg`: XLEN=32, REG_ADDR_W=5, NUM_REGS=32, and the wb entry type {rd[4:0], data[31:0]}. The register file uses the same constants.
- Sub-module `wb_fifo`: synchronous FIFO parameterised by depth and width, with push, pop, full, empty, count, and per-entry rd taps for busy_mask.
- Top-level logic: priority mux, starvation counter, output registers, err_waw.

## Test plan
- ALU only: alu_valid with rd=5, data=0xDEADBEEF at cycle 1 → write_en=1, write_addr=5, write_data=0xDEADBEEF in cycle 2; busy_mask=0x20 in cycle 2.
- MDU bypass: idle ALU, mdu_valid with rd=3, data=0x12 → write in the next cycle; fifo_count stays 0.
- Priority and queuing: ALU rd=1 and MDU rd=2 in the same cycle → x1 written in cycle +1, x2 written in cycle +2; busy_mask bit 2 set in between.
- Backpressure and starvation: FIFO_DEPTH=2, three MDU offers under continuous ALU traffic → third stalls with mdu_ready=0; alu_stall pulses after 4 waiting cycles; MDU writes drain in order.
- x0 and WAW: MDU rd=0 → handshake completes, no write, fifo_count=0. ALU rd=7 while x7 is queued → err_waw=1 and stays set.
- Reset mid-operation: rst with 2 entries queued → next cycle fifo_count=0, busy_mask=0, write_en=0, mdu_ready=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core constants, writeback entry type and small helpers.
package core_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   // rd sits in the MSBs so FIFO taps can pick it off the top of each entry
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

   localparam int WB_ENTRY_W = $bits(wb_entry_t);

   // Which producer owns the register file write port this cycle
   typedef enum logic [1:0] {
      SLOT_IDLE,
      SLOT_ALU,
      SLOT_FIFO,
      SLOT_BYPASS
   } wb_slot_e;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
      return NUM_REGS'(1) << rd;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for queued MDU results, with per-entry tag taps.
module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 37,
   parameter int TAP_W = 5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [WIDTH-1:0]              push_data,
   input  logic                          pop,
   output logic [WIDTH-1:0]              pop_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(DEPTH):0]        count,
   output logic [DEPTH-1:0]              occupied,
   output logic [DEPTH-1:0][TAP_W-1:0]   tap
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;

   // Storage array; contents need no reset since occupancy is tracked by count
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + PW'(1);
         end
         if (pop) begin
            rptr <= rptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign pop_data = mem[rptr];
   assign empty    = (count == '0);
   assign full     = (count == (PW+1)'(DEPTH));

   // Per-entry tag taps and occupancy: slot i is live when it lies within count of the read pointer
   always_comb begin
      logic [PW-1:0] off;
      occupied = '0;
      tap      = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         off         = PW'(i) - rptr;
         occupied[i] = ({1'b0, off} < count);
         tap[i]      = mem[i][WIDTH-1 -: TAP_W];
      end
   end

endmodule

// File: rtl/reg_wb_unit.sv
// Writeback stage: merges ALU and MDU results onto the register file write port.
module reg_wb_unit
   import core_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          alu_valid,
   input  logic [REG_ADDR_W-1:0]         alu_rd,
   input  logic [XLEN-1:0]               alu_data,
   output logic                          alu_stall,
   input  logic                          mdu_valid,
   output logic                          mdu_ready,
   input  logic [REG_ADDR_W-1:0]         mdu_rd,
   input  logic [XLEN-1:0]               mdu_data,
   output logic                          write_en,
   output logic [REG_ADDR_W-1:0]         write_addr,
   output logic [XLEN-1:0]               write_data,
   output logic [NUM_REGS-1:0]           busy_mask,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          err_waw
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   wb_slot_e                              slot;
   wb_entry_t                             sel;
   wb_entry_t                             fifo_head;
   wb_entry_t                             mdu_entry;
   logic                                  alu_take;
   logic                                  mdu_xfer;
   logic                                  mdu_keep;
   logic                                  fifo_push;
   logic                                  fifo_pop;
   logic                                  fifo_full;
   logic                                  fifo_empty;
   logic [FIFO_DEPTH-1:0]                 fifo_occ;
   logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] fifo_tap;
   logic                                  head_wait;
   logic [SW-1:0]                         starve_cnt;
   logic [SW-1:0]                         starve_inc;

   assign mdu_entry = '{rd: mdu_rd, data: mdu_data};

   wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WB_ENTRY_W),
      .TAP_W (REG_ADDR_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (mdu_entry),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .occupied  (fifo_occ),
      .tap       (fifo_tap)
   );

   // Ready is a function of stored occupancy only, so a same-cycle pop never frees a slot
   assign mdu_ready = !fifo_full;

   // Priority mux: ALU, then FIFO head, then MDU bypass; rd==0 results never claim the port
   always_comb begin
      alu_take   = alu_valid && (alu_rd != '0) && !alu_stall;
      mdu_xfer   = mdu_valid && mdu_ready;
      mdu_keep   = mdu_xfer && (mdu_rd != '0);
      slot       = SLOT_IDLE;
      sel        = '0;
      if (alu_take) begin
         slot = SLOT_ALU;
         sel  = '{rd: alu_rd, data: alu_data};
      end else if (!fifo_empty) begin
         slot = SLOT_FIFO;
         sel  = fifo_head;
      end else if (mdu_keep) begin
         slot = SLOT_BYPASS;
         sel  = mdu_entry;
      end
      fifo_pop   = (slot == SLOT_FIFO);
      fifo_push  = mdu_keep && (slot != SLOT_BYPASS);
      head_wait  = !fifo_empty && !fifo_pop;
      starve_inc = starve_cnt + SW'(1);
   end

   // Registered write port; address/data hold when idle since busy_mask gates on write_en
   always_ff @(posedge clk) begin
      if (rst) begin
         write_en   <= 1'b0;
         write_addr <= '0;
         write_data <= '0;
      end else begin
         write_en <= (slot != SLOT_IDLE);
         if (slot != SLOT_IDLE) begin
            write_addr <= sel.rd;
            write_data <= sel.data;
         end
      end
   end

   // Starvation counter; reaching the limit stalls the ALU for one cycle so the head drains
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
         alu_stall  <= 1'b0;
      end else begin
         starve_cnt <= head_wait ? starve_inc : '0;
         alu_stall  <= head_wait && (starve_inc == SW'(STARVE_LIMIT));
      end
   end

   // Pending destinations: every live FIFO entry plus the write currently on the port
   always_comb begin
      busy_mask = '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         if (fifo_occ[i]) begin
            busy_mask |= reg_onehot(fifo_tap[i]);
         end
      end
      if (write_en) begin
         busy_mask |= reg_onehot(write_addr);
      end
      busy_mask[0] = 1'b0;
   end

   // Sticky protocol error: ALU write to a pending register, or ALU result during a stall
   always_ff @(posedge clk) begin
      if (rst) begin
         err_waw <= 1'b0;
      end else if (alu_valid && (alu_stall || ((alu_rd != '0) && busy_mask[alu_rd]))) begin
         err_waw <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_wb_unit.sv
// Directed table-driven bench for reg_wb_unit (FIFO_DEPTH=2, STARVE_LIMIT=4).
module tb_reg_wb_unit;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_stall;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        write_en;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic [31:0] busy_mask;
   logic [1:0]  fifo_count;
   logic        err_waw;

   int tests;
   int fails;

   reg_wb_unit #(
      .FIFO_DEPTH   (2),
      .STARVE_LIMIT (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .alu_valid  (alu_valid),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .alu_stall  (alu_stall),
      .mdu_valid  (mdu_valid),
      .mdu_ready  (mdu_ready),
      .mdu_rd     (mdu_rd),
      .mdu_data   (mdu_data),
      .write_en   (write_en),
      .write_addr (write_addr),
      .write_data (write_data),
      .busy_mask  (busy_mask),
      .fifo_count (fifo_count),
      .err_waw    (err_waw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        av;
      logic [4:0]  ard;
      logic [31:0] adata;
      logic        mv;
      logic [4:0]  mrd;
      logic [31:0] mdata;
      logic        e_we;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      logic [1:0]  e_cnt;
      logic [31:0] e_busy;
      logic        e_rdy;
      logic        e_stall;
      logic        e_err;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(
      input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
      input logic mv, input logic [4:0] mrd, input logic [31:0] md,
      input logic we, input logic [4:0] wa, input logic [31:0] wd,
      input logic [1:0] cnt, input logic [31:0] busy, input logic rdy,
      input logic stall, input logic err);
      vec_t v;
      v.rst = r;   v.av = av; v.ard = ard; v.adata = ad;
      v.mv = mv;   v.mrd = mrd; v.mdata = md;
      v.e_we = we; v.e_addr = wa; v.e_data = wd; v.e_cnt = cnt;
      v.e_busy = busy; v.e_rdy = rdy; v.e_stall = stall; v.e_err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      rst       = 1'b1;
      alu_valid = 1'b0;
      alu_rd    = '0;
      alu_data  = '0;
      mdu_valid = 1'b0;
      mdu_rd    = '0;
      mdu_data  = '0;

      //           rst av ard  adata          mv mrd  mdata         we addr edata         cnt busy           rdy st er
      // ALU only
      vq.push_back(mk(0, 1, 5,  32'hDEADBEEF,  0, 0,  32'h0,         1, 5,  32'hDEADBEEF,  0, 32'h0000_0020, 1, 0, 0));
      // ALU rd=0 ignored
      vq.push_back(mk(0, 1, 0,  32'h0000_0099, 0, 0,  32'h0,         0, 5,  32'hDEADBEEF,  0, 32'h0000_0000, 1, 0, 0));
      // MDU bypass
      vq.push_back(mk(0, 0, 0,  32'h0,         1, 3,  32'h0000_0012, 1, 3,  32'h0000_0012,  0, 32'h0000_0008, 1, 0, 0));
      // ALU beats MDU, MDU queued
      vq.push_back(mk(0, 1, 1,  32'h0000_0111, 1, 2,  32'h0000_0222, 1, 1,  32'h0000_0111,  1, 32'h0000_0006, 1, 0, 0));
      vq.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,         1, 2,  32'h0000_0222,  0, 32'h0000_0004, 1, 0, 0));
      vq.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,         0, 2,  32'h0000_0222,  0, 32'h0000_0000, 1, 0, 0));
      // MDU rd=0 discarded
      vq.push_back(mk(0, 0, 0,  32'h0,         1, 0,  32'h0000_0055, 0, 2,  32'h0000_0222,  0, 32'h0000_0000, 1, 0, 0));
      // Backpressure and starvation under continuous ALU traffic
      vq.push_back(mk(0, 1, 10, 32'h0A00_0007, 1, 20, 32'h0000_1020, 1, 10, 32'h0A00_0007,  1, 32'h0010_0400, 1, 0, 0));
      vq.push_back(mk(0, 1, 11, 32'h0A00_0008, 1, 21, 32'h0000_1021, 1, 11, 32'h0A00_0008,  2, 32'h0030_0800, 0, 0, 0));
      vq.push_back(mk(0, 1, 10, 32'h0A00_0009, 1, 22, 32'h0000_1022, 1, 10, 32'h0A00_0009,  2, 32'h0030_0400, 0, 0, 0));
      vq.push_back(mk(0, 1, 11, 32'h0A00_000A, 1, 22, 32'h0000_1022, 1, 11, 32'h0A00_000A,  2, 32'h0030_0800, 0, 0, 0));
      vq.push_back(mk(0, 1, 10, 32'h0A00_000B, 1, 22, 32'h0000_1022, 1, 10, 32'h0A00_000B,  2, 32'h0030_0400, 0, 1, 0));
      vq.push_back(mk(0, 0, 0,  32'h0,         1, 22, 32'h0000_1022, 1, 20, 32'h0000_1020,  1, 32'h0030_0000, 1, 0, 0));
      vq.push_back(mk(0, 1, 11, 32'h0A00_000D, 1, 22, 32'h0000_1022, 1, 11, 32'h0A00_000D,  2, 32'h0060_0800, 0, 0, 0));
      vq.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,         1, 21, 32'h0000_1021,  1, 32'h0060_0000, 1, 0, 0));
      vq.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,         1, 22, 32'h0000_1022,  0, 32'h0040_0000, 1, 0, 0));
      vq.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,         0, 22, 32'h0000_1022,  0, 32'h0000_0000, 1, 0, 0));
      // WAW: ALU rd=7 while x7 queued
      vq.push_back(mk(0, 1, 12, 32'h0A00_0011, 1, 7,  32'h0000_1007, 1, 12, 32'h0A00_0011,  1, 32'h0000_1080, 1, 0, 0));
      vq.push_back(mk(0, 1, 7,  32'h0A00_0012, 0, 0,  32'h0,         1, 7,  32'h0A00_0012,  1, 32'h0000_0080, 1, 0, 1));
      vq.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,         1, 7,  32'h0000_1007,  0, 32'h0000_0080, 1, 0, 1));
      vq.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,         0, 7,  32'h0000_1007,  0, 32'h0000_0000, 1, 0, 1));
      // Reset with two entries queued
      vq.push_back(mk(0, 1, 12, 32'h0A00_0015, 1, 8,  32'h0000_1008, 1, 12, 32'h0A00_0015,  1, 32'h0000_1100, 1, 0, 1));
      vq.push_back(mk(0, 1, 13, 32'h0A00_0016, 1, 9,  32'h0000_1009, 1, 13, 32'h0A00_0016,  2, 32'h0000_2300, 0, 0, 1));
      vq.push_back(mk(1, 1, 14, 32'h0A00_0017, 0, 0,  32'h0,         0, 0,  32'h0,          0, 32'h0000_0000, 1, 0, 0));
      // ALU result during forced stall is dropped and flagged
      vq.push_back(mk(0, 1, 10, 32'h0A00_0018, 1, 20, 32'h0000_2020, 1, 10, 32'h0A00_0018,  1, 32'h0010_0400, 1, 0, 0));
      vq.push_back(mk(0, 1, 11, 32'h0A00_0019, 0, 0,  32'h0,         1, 11, 32'h0A00_0019,  1, 32'h0010_0800, 1, 0, 0));
      vq.push_back(mk(0, 1, 10, 32'h0A00_001A, 0, 0,  32'h0,         1, 10, 32'h0A00_001A,  1, 32'h0010_0400, 1, 0, 0));
      vq.push_back(mk(0, 1, 11, 32'h0A00_001B, 0, 0,  32'h0,         1, 11, 32'h0A00_001B,  1, 32'h0010_0800, 1, 0, 0));
      vq.push_back(mk(0, 1, 10, 32'h0A00_001C, 0, 0,  32'h0,         1, 10, 32'h0A00_001C,  1, 32'h0010_0400, 1, 1, 0));
      vq.push_back(mk(0, 1, 11, 32'h0A00_001D, 0, 0,  32'h0,         1, 20, 32'h0000_2020,  0, 32'h0010_0000, 1, 0, 1));
      vq.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,         0, 20, 32'h0000_2020,  0, 32'h0000_0000, 1, 0, 1));

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset write_en",   32'(write_en),   32'h0);
      chk("reset write_addr", 32'(write_addr), 32'h0);
      chk("reset write_data", write_data,      32'h0);
      chk("reset fifo_count", 32'(fifo_count), 32'h0);
      chk("reset busy_mask",  busy_mask,       32'h0);
      chk("reset mdu_ready",  32'(mdu_ready),  32'h1);
      chk("reset alu_stall",  32'(alu_stall),  32'h0);
      chk("reset err_waw",    32'(err_waw),    32'h0);

      for (int i = 0; i < vq.size(); i++) begin
         rst       = vq[i].rst;
         alu_valid = vq[i].av;
         alu_rd    = vq[i].ard;
         alu_data  = vq[i].adata;
         mdu_valid = vq[i].mv;
         mdu_rd    = vq[i].mrd;
         mdu_data  = vq[i].mdata;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d write_en", i), 32'(write_en), 32'(vq[i].e_we));
         if (vq[i].e_we) begin
            chk($sformatf("v%0d write_addr", i), 32'(write_addr), 32'(vq[i].e_addr));
            chk($sformatf("v%0d write_data", i), write_data,      vq[i].e_data);
         end
         chk($sformatf("v%0d fifo_count", i), 32'(fifo_count), 32'(vq[i].e_cnt));
         chk($sformatf("v%0d busy_mask", i),  busy_mask,       vq[i].e_busy);
         chk($sformatf("v%0d mdu_ready", i),  32'(mdu_ready),  32'(vq[i].e_rdy));
         chk($sformatf("v%0d alu_stall", i),  32'(alu_stall),  32'(vq[i].e_stall));
         chk($sformatf("v%0d err_waw", i),    32'(err_waw),    32'(vq[i].e_err));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
